mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
Sequencer and accumulator wrapped around the 16-bit projection MAC datapath (mac_16, LOW_PRE=0). It accepts a job of `len` operand pairs, each with a 2-bit projection code. It streams each pair into the combinational MAC through registered operand/ctrl lanes and accumulates the signed results into a wide accumulator. It returns one result per job over a valid/ready handshake, and sits between the operand feeder and the writeback stage.

Parameters:
INWID, 4, nibble count per operand; operand width is INWID*4 bits (16).
OUT_BIT, 32, width of the MAC result bus.
ACC_BIT, 40, accumulator/result width; must be at least OUT_BIT+1.
LEN_W, 8, width of the job length field.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  job start pulse; sampled only in IDLE.
len  input  LEN_W  number of operand pairs in the job; sampled with start.
op_valid  input  1  operand pair valid.
op_ready  output  1  controller accepts an operand pair.
op_a  input  INWID*4  operand a.
op_b  input  INWID*4  operand b.
op_code  input  2  projection code: 00 zero, 01 +a, 10 -a, 11 a*b.
mac_a  output  INWID*4  registered operand a to MAC.
mac_b  output  INWID*4  registered operand b to MAC.
mac_ctrl  output  2  registered ctrl to MAC.
mac_out  input  OUT_BIT  MAC result; combinational from mac_a/mac_b/mac_ctrl.
res_valid  output  1  result available.
res_ready  input  1  result consumer ready.
res_data  output  ACC_BIT  signed accumulated result.
overflow  output  1  sticky signed-overflow flag for the current or last job.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; acc=0; remaining count=0; mac_a, mac_b, mac_ctrl=0; stage-1 valid=0; op_ready, res_valid, busy, overflow=0; res_data=0. Reset asserted mid-job aborts the job with no result emitted.
- States:
  - IDLE: start=1 and len!=0 clears acc and overflow, loads count=len, goes to RUN. start=1 and len==0 clears acc and overflow, goes directly to DONE. Otherwise stays in IDLE.
  - RUN: op_ready=1. When op_valid&&op_ready, the next edge latches op_a/op_b/op_code into mac_a/mac_b/mac_ctrl, sets stage-1 valid, and decrements count. When the accepted pair is the last one (count==1), go to DRAIN. A cycle with no transfer loads mac_ctrl=00 and clears stage-1 valid; mac_a/mac_b hold.
  - DRAIN: op_ready=0; the final accumulate occurs; next edge goes to DONE.
  - DONE: res_valid=1 and res_data=acc, both held stable until res_ready=1. The handshake edge goes to IDLE and clears res_valid.
- Accumulate stage: on each edge where stage-1 valid=1, acc <= acc + ext(mac_out).
  - ext is sign-extension when the registered mac_ctrl==10, zero-extension otherwise, because an 11-code product is unsigned up to 0xFFFE0001.
  - Accumulator arithmetic is two's complement, ACC_BIT wide, and wraps on overflow.
- overflow: set when the signed ACC_BIT addition overflows (operands share a sign, result sign differs). It is sticky until the next accepted start.
- Latency: pair accepted at edge k, accumulated at edge k+1. After the last pair is accepted at edge L, DONE is entered at edge L+1 and res_valid is high from the cycle after edge L+1.
- Throughput: one pair per cycle with no bubbles; op_valid gaps insert bubbles only.
- start outside IDLE is ignored, and len is not re-sampled. op_valid outside RUN is ignored (op_ready=0).
- busy = (state != IDLE).

Test Plan:
- len=3, pairs {11,a=3,b=5}, {11,a=0x0010,b=0x0010}, {11,a=0xFFFF,b=0xFFFF} back-to-back -> res_data=0x00FFFE0110, overflow=0, res_valid 2 cycles after the last accept.
- len=3, pairs {01,a=100}, {10,a=250}, {00,a=7} -> res_data=-150 (0xFFFFFFFF6A), mac_ctrl sequence 01,10,00 then 00.
- start with len=0 -> DONE without touching the MAC; res_valid=1 with res_data=0 one cycle later.
- len=2 with one idle cycle between op_valid pulses; res_ready held low 5 cycles; start pulsed during DONE -> result held stable, start ignored, IDLE after the handshake.
- reset=1 for one cycle after 2 of 4 pairs are accepted -> next cycle all outputs 0 and state IDLE; a new len=1 {11,2,3} job then yields res_data=6.
- ACC_BIT=33, len=2, both {11,0xFFFF,0xFFFF} -> overflow=1, res_data wraps to 0x1FFFC0002 mod 2^33 (0x1FFFC0002).

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Job sequencer and wide signed accumulator around the combinational 16-bit
// projection MAC: registers operand/ctrl lanes, accumulates, returns one result per job.
module mac_seq_ctrl #(
  parameter int INWID   = 4,
  parameter int OUT_BIT = 32,
  parameter int ACC_BIT = 40,
  parameter int LEN_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [INWID*4-1:0]   op_a,
  input  logic [INWID*4-1:0]   op_b,
  input  logic [1:0]           op_code,
  output logic [INWID*4-1:0]   mac_a,
  output logic [INWID*4-1:0]   mac_b,
  output logic [1:0]           mac_ctrl,
  input  logic [OUT_BIT-1:0]   mac_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_BIT-1:0]   res_data,
  output logic                 overflow,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [LEN_W-1:0]   count;
  logic               s1_valid;
  logic [ACC_BIT-1:0] acc;
  logic [ACC_BIT-1:0] addend;
  logic [ACC_BIT-1:0] sum;
  logic               add_ovf;
  logic               xfer;
  logic               start_ok;

  assign xfer     = op_valid && (state == RUN);
  assign start_ok = start && (state == IDLE);
  assign busy     = (state != IDLE);
  assign res_data = acc;

  // Only the negate code yields a signed MAC result; a*b can reach 0xFFFE0001 unsigned.
  always_comb begin
    addend  = {{(ACC_BIT-OUT_BIT){1'b0}}, mac_out};
    if (mac_ctrl == 2'b10)
      addend = {{(ACC_BIT-OUT_BIT){mac_out[OUT_BIT-1]}}, mac_out};
    sum     = acc + addend;
    add_ovf = (acc[ACC_BIT-1] == addend[ACC_BIT-1]) && (sum[ACC_BIT-1] != acc[ACC_BIT-1]);
  end

  always_comb begin
    state_next = state;
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        op_ready = 1'b1;
        if (op_valid && (count == LEN_W'(1)))
          state_next = DRAIN;
      end
      DRAIN: state_next = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Idle cycles push a zero ctrl into the MAC so a stale product is never re-added.
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_a    <= '0;
      mac_b    <= '0;
      mac_ctrl <= '0;
      s1_valid <= 1'b0;
      count    <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (xfer) begin
        mac_a    <= op_a;
        mac_b    <= op_b;
        mac_ctrl <= op_code;
        s1_valid <= 1'b1;
        count    <= count - LEN_W'(1);
      end else begin
        mac_ctrl <= 2'b00;
        s1_valid <= 1'b0;
      end
      if (start_ok) begin
        acc      <= '0;
        overflow <= 1'b0;
        count    <= len;
      end else if (s1_valid) begin
        acc <= sum;
        if (add_ovf)
          overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: a behavioural MAC model feeds mac_out, expected
// results are queued at job start and checked by monitors at each result handshake.
module tb_mac_seq_ctrl;

  typedef struct packed {
    logic [39:0] data;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        start33;
  logic [7:0]  len;
  logic        op_valid;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [1:0]  op_code;
  logic        res_ready;

  logic        op_ready;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [1:0]  mac_ctrl;
  logic [31:0] mac_out;
  logic        res_valid;
  logic [39:0] res_data;
  logic        overflow;
  logic        busy;

  logic        op_ready33;
  logic [15:0] mac_a33;
  logic [15:0] mac_b33;
  logic [1:0]  mac_ctrl33;
  logic [31:0] mac_out33;
  logic        res_valid33;
  logic [32:0] res_data33;
  logic        overflow33;
  logic        busy33;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t exp_q33[$];
  exp_t item;
  exp_t item33;

  function automatic logic [31:0] mac_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] c);
    case (c)
      2'b01:   return {16'h0, a};
      2'b10:   return 32'h0 - {16'h0, a};
      2'b11:   return {16'h0, a} * {16'h0, b};
      default: return 32'h0;
    endcase
  endfunction

  assign mac_out   = mac_model(mac_a, mac_b, mac_ctrl);
  assign mac_out33 = mac_model(mac_a33, mac_b33, mac_ctrl33);

  mac_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .mac_a(mac_a), .mac_b(mac_b), .mac_ctrl(mac_ctrl), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .overflow(overflow), .busy(busy)
  );

  mac_seq_ctrl #(.ACC_BIT(33)) dut33 (
    .clk(clk), .reset(reset), .start(start33), .len(len),
    .op_valid(op_valid), .op_ready(op_ready33), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .mac_a(mac_a33), .mac_b(mac_b33), .mac_ctrl(mac_ctrl33), .mac_out(mac_out33),
    .res_valid(res_valid33), .res_ready(res_ready), .res_data(res_data33),
    .overflow(overflow33), .busy(busy33)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startJob(input logic [7:0] n, input bit use33);
    len = n;
    if (use33) start33 = 1'b1;
    else       start   = 1'b1;
    tick();
    start   = 1'b0;
    start33 = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
    op_valid = 1'b1;
    op_code  = c;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic waitIdle(input bit use33);
    int n = 0;
    while ((use33 ? busy33 : busy) && n < 50) begin
      tick();
      n++;
    end
    checkOutput("idle_timeout", 64'(use33 ? busy33 : busy), 64'(0));
    res_ready = 1'b0;
  endtask

  // Result monitors: pop one expectation per handshake seen at the falling edge.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result actual=%0h expected=none", res_data);
      end else begin
        item = exp_q.pop_front();
        checkOutput("res_data", 64'(res_data), 64'(item.data));
        checkOutput("overflow", 64'(overflow), 64'(item.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (res_valid33 && res_ready) begin
      if (exp_q33.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result33 actual=%0h expected=none", res_data33);
      end else begin
        item33 = exp_q33.pop_front();
        checkOutput("res_data33", 64'(res_data33), 64'(item33.data));
        checkOutput("overflow33", 64'(overflow33), 64'(item33.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start33 = 1'b0; len = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; op_code = '0; res_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_res_valid", 64'(res_valid), 64'(0));
    checkOutput("rst_res_data", 64'(res_data), 64'(0));
    checkOutput("rst_op_ready", 64'(op_ready), 64'(0));

    // Three back-to-back products, last one the largest unsigned a*b.
    exp_q.push_back({40'h00FFFE0110, 1'b0});
    startJob(8'd3, 1'b0);
    applyStimulus(2'b11, 16'd3, 16'd5);
    applyStimulus(2'b11, 16'h0010, 16'h0010);
    applyStimulus(2'b11, 16'hFFFF, 16'hFFFF);
    checkOutput("t1_valid_drain", 64'(res_valid), 64'(0));
    tick();
    checkOutput("t1_valid_done", 64'(res_valid), 64'(1));
    res_ready = 1'b1;
    waitIdle(1'b0);

    // Signed mix: +100, -250, zero code.
    exp_q.push_back({40'hFFFFFFFF6A, 1'b0});
    startJob(8'd3, 1'b0);
    applyStimulus(2'b01, 16'd100, 16'd0);
    checkOutput("t2_ctrl0", 64'(mac_ctrl), 64'(2'b01));
    checkOutput("t2_mac_a0", 64'(mac_a), 64'(100));
    applyStimulus(2'b10, 16'd250, 16'd0);
    checkOutput("t2_ctrl1", 64'(mac_ctrl), 64'(2'b10));
    applyStimulus(2'b00, 16'd7, 16'd0);
    checkOutput("t2_ctrl2", 64'(mac_ctrl), 64'(2'b00));
    tick();
    checkOutput("t2_ctrl3", 64'(mac_ctrl), 64'(2'b00));
    res_ready = 1'b1;
    waitIdle(1'b0);

    // Zero-length job goes straight to DONE.
    exp_q.push_back({40'h0, 1'b0});
    startJob(8'd0, 1'b0);
    checkOutput("t3_valid", 64'(res_valid), 64'(1));
    checkOutput("t3_ctrl", 64'(mac_ctrl), 64'(0));
    res_ready = 1'b1;
    waitIdle(1'b0);

    // Bubble between pairs, consumer stalls, stray start during DONE.
    exp_q.push_back({40'h0000001273, 1'b0});
    startJob(8'd2, 1'b0);
    applyStimulus(2'b11, 16'd7, 16'd9);
    tick();
    checkOutput("t4_ready_bubble", 64'(op_ready), 64'(1));
    applyStimulus(2'b01, 16'h1234, 16'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_valid", 64'(res_valid), 64'(1));
      checkOutput("t4_hold_data", 64'(res_data), 64'(40'h1273));
      if (i == 1) begin
        start = 1'b1;
        len   = 8'd5;
      end
      tick();
      start = 1'b0;
    end
    res_ready = 1'b1;
    waitIdle(1'b0);
    tick();
    checkOutput("t4_idle_busy", 64'(busy), 64'(0));
    checkOutput("t4_idle_valid", 64'(res_valid), 64'(0));

    // Reset in the middle of a job aborts it silently.
    startJob(8'd4, 1'b0);
    applyStimulus(2'b11, 16'd2, 16'd2);
    applyStimulus(2'b11, 16'd4, 16'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_busy", 64'(busy), 64'(0));
    checkOutput("t5_op_ready", 64'(op_ready), 64'(0));
    checkOutput("t5_res_valid", 64'(res_valid), 64'(0));
    checkOutput("t5_res_data", 64'(res_data), 64'(0));
    checkOutput("t5_mac", 64'({mac_a, mac_b, mac_ctrl}), 64'(0));
    checkOutput("t5_overflow", 64'(overflow), 64'(0));
    exp_q.push_back({40'd6, 1'b0});
    startJob(8'd1, 1'b0);
    applyStimulus(2'b11, 16'd2, 16'd3);
    res_ready = 1'b1;
    waitIdle(1'b0);

    // Narrow accumulator: two max products overflow the signed 33-bit range.
    exp_q33.push_back({40'h01FFFC0002, 1'b1});
    startJob(8'd2, 1'b1);
    checkOutput("t6_ready33", 64'(op_ready33), 64'(1));
    applyStimulus(2'b11, 16'hFFFF, 16'hFFFF);
    applyStimulus(2'b11, 16'hFFFF, 16'hFFFF);
    res_ready = 1'b1;
    waitIdle(1'b1);

    tick();
    checkOutput("queue_empty", 64'(exp_q.size()), 64'(0));
    checkOutput("queue33_empty", 64'(exp_q33.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
